// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: store buffer between the CPU data port and a single-ported,
// combinational-read data_memory. Stores retire into a circular FIFO with zero
// latency to the CPU and drain to memory whenever the port is not claimed by the
// CPU. Loads forward from the youngest matching buffered store, otherwise they
// read memory directly and take priority over draining.
//
// Configuration:
//   WBUF_COALESCE_EN  when defined, a store to the word address of the youngest
//                     buffered entry (not draining this cycle) overwrites that
//                     entry's data instead of allocating a new one.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   cpu_mem_read/write        CPU load/store request for this cycle
//   cpu_addr, cpu_wdata       CPU byte address (bits [1:0] ignored for matching), store data
//   cpu_rdata                 load data to the CPU (combinational)
//   cpu_stall                 CPU must hold its request (store into a full buffer)
//   mem_read/write            data_memory strobes
//   mem_addr, mem_wdata       data_memory address and write data
//   mem_rdata                 data_memory combinational read data
//   wbuf_empty, wbuf_count    buffer occupancy
module dmem_write_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_mem_read,
    input  logic                     cpu_mem_write,
    input  logic [31:0]              cpu_addr,
    input  logic [31:0]              cpu_wdata,
    output logic [31:0]              cpu_rdata,
    output logic                     cpu_stall,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata,
    output logic                     wbuf_empty,
    output logic [$clog2(DEPTH):0]   wbuf_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [PW-1:0] PtrOne = 1;
    localparam logic [CW-1:0] CntOne = 1;
    localparam logic [CW-1:0] CntFull = CW'(DEPTH);

    logic [29:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;

    logic          store_req;
    logic          load_req;
    logic          dual_req;
    logic          hit;
    logic [31:0]   hit_data;
    logic [PW-1:0] idx;
    logic          buf_empty;
    logic          full;
    logic          load_miss;
    logic          drain;
    logic          coalesce;
    logic          enq;

    // Requests are masked while reset is held so no strobe leaks out.
    assign store_req = cpu_mem_write & ~rst;
    assign load_req  = cpu_mem_read & ~cpu_mem_write & ~rst;
    assign dual_req  = cpu_mem_read & cpu_mem_write & ~rst;

    // Walk oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = head_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (valid_q[idx] && (addr_q[idx] == cpu_addr[31:2])) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    assign buf_empty = (count_q == '0);
    assign full      = (count_q == CntFull);
    assign load_miss = load_req & ~hit;

    // A cycle carrying both requests keeps the port for the CPU: the store is
    // accepted, the load is dropped, and the buffer does not drain. This is the
    // only way the CPU can hold the buffer back while it keeps issuing stores.
    assign drain = ~buf_empty & ~load_miss & ~dual_req;

`ifdef WBUF_COALESCE_EN
    logic [PW-1:0] youngest;
    assign youngest = tail_q - PtrOne;
    // The youngest entry is draining only when it is also the head.
    assign coalesce = store_req & ~buf_empty & valid_q[youngest]
                    & (addr_q[youngest] == cpu_addr[31:2])
                    & ~(drain && (count_q == CntOne));
`else
    assign coalesce = 1'b0;
`endif

    assign cpu_stall = store_req & full & ~coalesce;
    assign enq       = store_req & ~full & ~coalesce;

    always_comb begin
        mem_read  = load_miss;
        mem_write = drain;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_rdata = '0;
        if (load_miss) begin
            mem_addr = cpu_addr;
        end else if (drain) begin
            mem_addr = {addr_q[head_q], 2'b00};
        end
        if (drain) begin
            mem_wdata = data_q[head_q];
        end
        if (load_req) begin
            cpu_rdata = hit ? hit_data : mem_rdata;
        end
    end

    assign wbuf_empty = buf_empty;
    assign wbuf_count = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            // Head and tail never coincide when both drain and enq fire.
            if (drain) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PtrOne;
            end
            if (enq) begin
                addr_q[tail_q]  <= cpu_addr[31:2];
                data_q[tail_q]  <= cpu_wdata;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PtrOne;
            end
`ifdef WBUF_COALESCE_EN
            if (coalesce) begin
                data_q[youngest] <= cpu_wdata;
            end
`endif
            if (enq && !drain) begin
                count_q <= count_q + CntOne;
            end else if (drain && !enq) begin
                count_q <= count_q - CntOne;
            end
        end
    end

endmodule

// File: doc/dmem_write_buffer.md
DMEM_WRITE_BUFFER -- requirements
Module: dmem_write_buffer

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of store entries (power of two, >=2).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: cpu_mem_read  input  1  CPU load request, this cycle.
REQ-005 SHALL have port: cpu_mem_write  input  1  CPU store request, this cycle.
REQ-006 SHALL have port: cpu_addr  input  32  CPU byte address; bits [1:0] ignored.
REQ-007 SHALL have port: cpu_wdata  input  32  CPU store data.
REQ-008 SHALL have port: cpu_rdata  output  32  load data returned to the CPU, combinational.
REQ-009 SHALL have port: cpu_stall  output  1  CPU shall hold its current request.
REQ-010 SHALL have port: mem_read  output  1  read strobe to data_memory.
REQ-011 SHALL have port: mem_write  output  1  write strobe to data_memory (written at clk edge).
REQ-012 SHALL have port: mem_addr  output  32  data_memory address.
REQ-013 SHALL have port: mem_wdata  output  32  data_memory write data.
REQ-014 SHALL have port: mem_rdata  input  32  data_memory combinational read data.
REQ-015 SHALL have port: wbuf_empty  output  1  no stores pending (fence indication).
REQ-016 SHALL have port: wbuf_count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-017 SHALL hold stores in a circular FIFO (head, tail pointers, count); entry = word address [31:2] + 32-bit data.
REQ-018 Store, not full: SHALL enqueue {cpu_addr, cpu_wdata} at tail on the edge; cpu_stall=0; zero-cycle latency to CPU.
REQ-019 Store, full: SHALL assert cpu_stall combinationally, not enqueue; drain of head proceeds same cycle, so the store is accepted the following cycle.
REQ-020 Load: SHALL compare cpu_addr[31:2] against all valid entries; youngest matching entry wins.
REQ-021 Load hit: cpu_rdata = matching entry data, mem_read=0, cpu_stall=0; drain may use the memory port this cycle.
REQ-022 Load miss: mem_read=1, mem_addr=cpu_addr, cpu_rdata=mem_rdata, no drain this cycle (load has port priority).
REQ-023 Drain: when count>0 and port not used by a load miss, mem_write=1, mem_addr={head addr,2'b00}, mem_wdata=head data; head pops on the edge.
REQ-024 Enqueue and drain in the same cycle SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-025 Load hitting the head entry while it drains SHALL still forward the buffered data.
REQ-026 cpu_mem_read and cpu_mem_write both high: store SHALL take precedence; load ignored; cpu_rdata=0.
REQ-027 Idle (no request, count=0): mem_read=mem_write=0, mem_addr=mem_wdata=0, cpu_rdata=0.
REQ-028 wbuf_empty SHALL equal (count==0); wbuf_count reflects registered count.
REQ-029 Memory-side stores SHALL reach data_memory in CPU program order (except as REQ-033 allows).

Reset
REQ-030 While rst=1: head=tail=count=0, all entries invalid, cpu_stall=0, mem_read=mem_write=0, wbuf_empty=1, wbuf_count=0.
REQ-031 Reset asserted mid-operation SHALL discard all pending stores immediately (asynchronous); no further mem_write until a new store.
REQ-032 First store after reset release SHALL be accepted on the first rising edge with rst=0.

Configuration
REQ-033 Macro WBUF_COALESCE_EN defined: store whose word address matches the youngest valid entry, and that entry is not draining this cycle, SHALL overwrite its data instead of allocating (count unchanged, no stall even if full).
REQ-034 Macro WBUF_COALESCE_EN undefined: every accepted store SHALL allocate a new entry.

Verification
REQ-035 Reset, then store 0x4<-30, idle 1 cycle -> mem_write=1, mem_addr=0x4, mem_wdata=30 that cycle; wbuf_empty=1 after.
REQ-036 Store 0x8<-7, then immediately load 0x8 -> cpu_rdata=7, mem_read=0.
REQ-037 Preload mem[0]=10; load 0x0 with store pending at 0xC -> mem_read=1, cpu_rdata=10, no mem_write that cycle; drain next cycle.
REQ-038 Five back-to-back stores, DEPTH=4, concurrent loads blocking drain -> cpu_stall=1 on fifth; all five written in order 0x0,0x4,0x8,0xC,0x10.
REQ-039 Stores 0x4<-1, 0x4<-2 consecutively with loads blocking drain -> with WBUF_COALESCE_EN wbuf_count=1 and one write of 2; without, count=2, writes 1 then 2.
REQ-040 Three stores queued, assert rst one cycle -> wbuf_count=0, no mem_write after release.
